// File: rtl/instr_fetch_ctrl.sv
// Fetch/decode/sequencer: fetches one instruction, holds it for HOLD_CYCLES clocks
// while the datapath settles, decodes control words and computes the next PC.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          HOLD_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        alu_zero,
  output logic [31:0] instr_out,
  output logic [8:0]  ctrlunit,
  output logic [3:0]  ctrl,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT  = 4'(HOLD_CYCLES - 1);
  localparam logic [8:0] GATE_MASK = 9'h0BF;  // clears RegWrite[8] and MemWrite[6]
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_HALT   = 6'b111111;

  // Returns {ctrlunit[8:0], ctrl[3:0]} for an instruction word.
  function automatic logic [12:0] decode(input logic [31:0] ins);
    logic [12:0] r;
    r = 13'h0;
    case (ins[31:26])
      OP_RTYPE: begin
        case (ins[5:0])
          6'b100000: r = {9'h121, 4'b0010};
          6'b100010: r = {9'h121, 4'b0110};
          6'b100100: r = {9'h121, 4'b0000};
          6'b100101: r = {9'h121, 4'b0001};
          6'b101010: r = {9'h121, 4'b0111};
          default:   r = 13'h0;
        endcase
      end
      OP_LW:   r = {9'h18C, 4'b0010};
      OP_SW:   r = {9'h0C0, 4'b0010};
      OP_ADDI: r = {9'h180, 4'b0010};
      OP_BEQ:  r = {9'h012, 4'b0110};
      OP_J:    r = {9'h000, 4'b0000};
      default: r = 13'h0;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [8:0]  dec_q, dec_d;
  logic [8:0]  cu_q, cu_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        valid_q, valid_d;
  logic        halt_q, halt_d;

  logic [12:0] dec_s;
  logic [31:0] p4_s;
  logic [31:0] next_pc_s;

  assign dec_s = decode(imem_data);
  assign p4_s  = pc_q + 32'd4;

  // Next-PC selection, evaluated with the held instruction on the last EXEC cycle.
  always_comb begin
    next_pc_s = p4_s;
    if (instr_q[31:26] == OP_BEQ && alu_zero) begin
      next_pc_s = p4_s + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    end else if (instr_q[31:26] == OP_J) begin
      next_pc_s = {p4_s[31:28], instr_q[25:0], 2'b00};
    end else begin
      next_pc_s = p4_s;
    end
  end

  // Sequencer next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    dec_d   = dec_q;
    cu_d    = cu_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    case (state_q)
      ST_FETCH: begin
        instr_d = imem_data;
        if (imem_data[31:26] == OP_HALT) begin
          state_d = ST_HALT;
          dec_d   = 9'h000;
          cu_d    = 9'h000;
          ctrl_d  = 4'h0;
          halt_d  = 1'b1;
        end else begin
          state_d = ST_EXEC;
          cnt_d   = 4'd0;
          dec_d   = dec_s[12:4];
          cu_d    = dec_s[12:4] & GATE_MASK;
          ctrl_d  = dec_s[3:0];
          valid_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FETCH;
          cnt_d   = 4'd0;
          pc_d    = next_pc_s;
          cu_d    = dec_q & GATE_MASK;
          valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          // Write strobes open only for the final hold cycle.
          if (cnt_q + 4'd1 == LAST_CNT) begin
            cu_d = dec_q;
          end else begin
            cu_d = dec_q & GATE_MASK;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cnt_q   <= 4'd0;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      dec_q   <= 9'h000;
      cu_q    <= 9'h000;
      ctrl_q  <= 4'h0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      dec_q   <= dec_d;
      cu_q    <= cu_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_out   = instr_q;
  assign ctrlunit    = cu_q;
  assign ctrl        = ctrl_q;
  assign instr_valid = valid_q;
  assign halted      = halt_q;

endmodule
